// File: rtl/mac_pkg.sv
// Shared types and saturating-add helper for the multiply-accumulate stage.
package mac_pkg;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} mac_state_e;

  // Widest accumulator the saturating adder supports.
  localparam int unsigned SAT_MAX_W = 64;

  typedef struct packed {
    logic                 ovf;
    logic [SAT_MAX_W-1:0] sum;
  } sat_res_t;

  // Unsigned add that clamps to 2^acc_width-1. The caller passes its
  // ACC_WIDTH and uses the low acc_width bits of .sum.
  function automatic sat_res_t sat_add(input logic [SAT_MAX_W-1:0] acc,
                                       input logic [SAT_MAX_W-1:0] prod,
                                       input int unsigned          acc_width);
    logic [SAT_MAX_W:0] sum;
    logic [SAT_MAX_W:0] lim;
    sat_res_t           res;
    sum     = {1'b0, acc} + {1'b0, prod};
    lim     = ({{SAT_MAX_W{1'b0}}, 1'b1} << acc_width) - {{SAT_MAX_W{1'b0}}, 1'b1};
    res.ovf = (sum > lim);
    res.sum = res.ovf ? lim[SAT_MAX_W-1:0] : sum[SAT_MAX_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/mac_accumulator_multiplier.sv
// Combinational unsigned multiplier feeding the accumulator.
module multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

  // Full-width product, no pipelining.
  always_comb product = a * b;

endmodule

// File: rtl/mac_accumulator.sv
// Saturating multiply-accumulate: sums LEN products per result and
// presents each result on a valid/ready port.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned LEN       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 overflow
);

  localparam int unsigned CW = (LEN > 1) ? $clog2(LEN + 1) : 1;

  mac_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] acc_out_q, acc_out_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [2*WIDTH-1:0]   product;
  sat_res_t             sat_r;
  logic                 sat_unused;
  logic                 accept;

  multiplier #(.WIDTH(WIDTH)) u_mult (
    .a       (a),
    .b       (b),
    .product (product)
  );

  assign sat_r      = sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(product), ACC_WIDTH);
  assign sat_unused = ^sat_r;

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign acc_out   = acc_out_q;
  assign overflow  = ovf_q;

  // Next-state: clear wins over everything; acc_out is loaded on entry to HOLD
  // so it is already valid in the first out_valid cycle.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    acc_out_d = acc_out_q;
    if (clear) begin
      state_d   = IDLE;
      acc_d     = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
      acc_out_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d = ACC_WIDTH'(product);
            cnt_d = CW'(1);
            if (LEN == 1) begin
              state_d   = HOLD;
              acc_out_d = ACC_WIDTH'(product);
            end else begin
              state_d = ACC;
            end
          end
        end
        ACC: begin
          if (accept) begin
            acc_d = sat_r.sum[ACC_WIDTH-1:0];
            ovf_d = ovf_q | sat_r.ovf;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(LEN - 1)) begin
              state_d   = HOLD;
              acc_out_d = sat_r.sum[ACC_WIDTH-1:0];
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      acc_out_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      acc_out_q <= acc_out_d;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench: three configurations (default, 16-bit accumulator, LEN=1).
module tb_mac_accumulator;

  typedef struct packed {
    logic [23:0] acc;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr[3];
  logic        iv[3];
  logic        ordy[3];
  logic [7:0]  opa[3];
  logic [7:0]  opb[3];
  logic        irdy[3];
  logic        ov[3];
  logic        ovf[3];
  logic [23:0] acc[3];
  logic [15:0] acc16;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   drn[3];
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign acc[1] = {8'h00, acc16};

  mac_accumulator #(.WIDTH(8), .ACC_WIDTH(24), .LEN(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clr[0]), .in_valid(iv[0]), .in_ready(irdy[0]),
    .a(opa[0]), .b(opb[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .acc_out(acc[0]), .overflow(ovf[0])
  );

  mac_accumulator #(.WIDTH(8), .ACC_WIDTH(16), .LEN(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clr[1]), .in_valid(iv[1]), .in_ready(irdy[1]),
    .a(opa[1]), .b(opb[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .acc_out(acc16), .overflow(ovf[1])
  );

  mac_accumulator #(.WIDTH(8), .ACC_WIDTH(24), .LEN(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clr[2]), .in_valid(iv[2]), .in_ready(irdy[2]),
    .a(opa[2]), .b(opb[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .acc_out(acc[2]), .overflow(ovf[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drain_seen(input int d, input exp_t e, input logic have);
    drn[d]++;
    if (!have) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_result_dut%0d: got acc_out=%0d, expected no result", d, acc[d]);
    end else begin
      check($sformatf("result_acc_dut%0d", d), acc[d], 32'(e.acc));
      check($sformatf("result_ovf_dut%0d", d), ovf[d], 32'(e.ovf));
    end
  endtask

  // Present one pair and hold it until accepted; c = cycle of the accept edge.
  task automatic send(input int d, input logic [7:0] x, input logic [7:0] y, output int c);
    int n;
    n = 0;
    opa[d] = x;
    opb[d] = y;
    iv[d]  = 1'b1;
    while (!irdy[d] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!irdy[d]) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout_dut%0d: got in_ready=0, expected 1 within 40 cycles", d);
    end
    @(posedge clk); #1;
    c = cyc;
    iv[d] = 1'b0;
  endtask

  task automatic send4(input int d, input logic [7:0] x, input logic [7:0] y);
    int c;
    for (int i = 0; i < 4; i++) send(d, x, y, c);
  endtask

  task automatic wait_drain(input int d, input int n);
    int k;
    k = 0;
    while (drn[d] < n && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    check($sformatf("drain_count_dut%0d", d), 32'(drn[d]), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c2, c3;
    for (int d = 0; d < 3; d++) begin
      clr[d] = 1'b0; iv[d] = 1'b0; ordy[d] = 1'b0;
      opa[d] = '0; opb[d] = '0; drn[d] = 0;
    end

    // Monitor: pops an expectation on every output handshake.
    fork
      begin : monitor
        exp_t e;
        logic have;
        forever begin
          @(negedge clk);
          if (rst_n) begin
            if (ov[0] && ordy[0]) begin
              have = (q0.size() != 0); e = '0;
              if (have) e = q0.pop_front();
              drain_seen(0, e, have);
            end
            if (ov[1] && ordy[1]) begin
              have = (q1.size() != 0); e = '0;
              if (have) e = q1.pop_front();
              drain_seen(1, e, have);
            end
            if (ov[2] && ordy[2]) begin
              have = (q2.size() != 0); e = '0;
              if (have) e = q2.pop_front();
              drain_seen(2, e, have);
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_out_valid", ov[0], 0);
    check("reset_acc_out", acc[0], 0);
    check("reset_overflow", ovf[0], 0);
    check("reset_in_ready", irdy[0], 1);

    // Basic back-to-back sum: 10+20+30+40.
    ordy[0] = 1'b1;
    q0.push_back('{acc: 24'd100, ovf: 1'b0});
    send(0, 8'd1, 8'd10, c0);
    send(0, 8'd2, 8'd10, c1);
    send(0, 8'd3, 8'd10, c2);
    send(0, 8'd4, 8'd10, c3);
    check("basic_back_to_back_accepts", 32'(c3 - c0), 3);
    check("basic_out_valid_after_last", ov[0], 1);
    check("basic_in_ready_in_hold", irdy[0], 0);
    @(posedge clk); #1;
    check("basic_out_valid_one_cycle", ov[0], 0);
    check("basic_in_ready_back", irdy[0], 1);
    wait_drain(0, 1);

    // Bubbles between pairs and backpressure while holding.
    ordy[0] = 1'b0;
    q0.push_back('{acc: 24'd100, ovf: 1'b0});
    for (int i = 1; i <= 4; i++) begin
      send(0, 8'(i), 8'd10, c0);
      if (i < 4) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end
    for (int k = 0; k < 3; k++) begin
      check("bp_out_valid_held", ov[0], 1);
      check("bp_acc_out_stable", acc[0], 100);
      check("bp_overflow_stable", ovf[0], 0);
      check("bp_in_ready_low", irdy[0], 0);
      @(posedge clk); #1;
    end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_out_valid", ov[0], 0);
    check("bp_idle_in_ready", irdy[0], 1);
    check("bp_acc_out_kept", acc[0], 100);
    wait_drain(0, 2);

    // Clear mid-accumulation with a pair presented in the same cycle.
    send(0, 8'd5, 8'd5, c0);
    send(0, 8'd6, 8'd6, c0);
    opa[0] = 8'd7; opb[0] = 8'd7; iv[0] = 1'b1; clr[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0; clr[0] = 1'b0;
    check("clear_in_ready", irdy[0], 1);
    check("clear_out_valid", ov[0], 0);
    check("clear_acc_out_zero", acc[0], 0);
    check("clear_overflow", ovf[0], 0);
    q0.push_back('{acc: 24'd8, ovf: 1'b0});
    send4(0, 8'd1, 8'd2);
    wait_drain(0, 3);

    // Async reset with count=3; acc_out holds 8 beforehand.
    send(0, 8'd3, 8'd3, c0);
    send(0, 8'd3, 8'd3, c0);
    send(0, 8'd3, 8'd3, c0);
    #2 rst_n = 1'b0;
    #1;
    check("areset_out_valid", ov[0], 0);
    check("areset_acc_out", acc[0], 0);
    check("areset_overflow", ovf[0], 0);
    check("areset_in_ready", irdy[0], 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    q0.push_back('{acc: 24'd36, ovf: 1'b0});
    send4(0, 8'd3, 8'd3);
    wait_drain(0, 4);

    // Saturation on the 16-bit accumulator, then a clean result.
    ordy[1] = 1'b1;
    q1.push_back('{acc: 24'd65535, ovf: 1'b1});
    send4(1, 8'd255, 8'd255);
    wait_drain(1, 1);
    q1.push_back('{acc: 24'd4, ovf: 1'b0});
    send4(1, 8'd1, 8'd1);
    wait_drain(1, 2);

    // LEN=1: immediate result, then back-to-back pairs every second cycle.
    ordy[2] = 1'b1;
    q2.push_back('{acc: 24'd20000, ovf: 1'b0});
    send(2, 8'd200, 8'd100, c0);
    check("len1_out_valid_next", ov[2], 1);
    check("len1_acc_out", acc[2], 20000);
    wait_drain(2, 1);
    q2.push_back('{acc: 24'd1, ovf: 1'b0});
    q2.push_back('{acc: 24'd65025, ovf: 1'b0});
    q2.push_back('{acc: 24'd0, ovf: 1'b0});
    send(2, 8'd1, 8'd1, c0);
    send(2, 8'd255, 8'd255, c1);
    send(2, 8'd0, 8'd9, c2);
    check("len1_spacing_1", 32'(c1 - c0), 2);
    check("len1_spacing_2", 32'(c2 - c1), 2);
    wait_drain(2, 4);

    check("scoreboard0_empty", 32'(q0.size()), 0);
    check("scoreboard1_empty", 32'(q1.size()), 0);
    check("scoreboard2_empty", 32'(q2.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
